pipe_stage_chain: RTL and testbench

Parametrised, elastic successor to the fixed single-cycle pipeline latch between execute and memory stages.
- Carries a generic payload plus destination-register and write-enable side fields through DEPTH register stages.
- Per-stage valid bits, valid/ready backpressure with bubble collapsing, and synchronous flush.
- Combinational RAW-hazard lookup across all in-flight stages for the decode/forwarding logic.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_stage_cell.sv | 63 ++++++
 rtl/pipe_stage_chain.sv | 171 +++++++++++++++++
 tb/tb_pipe_stage_chain.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline chain (pipe_stage_chain).
// Holds the depth limit, default field widths, the per-stage control
// encoding and the saturating counter helper used by the optional
// stall counter (enabled with PIPE_STALL_CNT_EN).
package pipe_pkg;

    // Upper bound on the number of register stages in a chain.
    localparam int PIPE_MAX_DEPTH = 8;

    // Default widths of the entry fields.
    localparam int PIPE_RD_W      = 5;
    localparam int PIPE_PAYLOAD_W = 128;

    // Per-stage update operation chosen by the chain's advance logic.
    typedef enum logic [1:0] {
        CELL_HOLD  = 2'd0,  // keep valid bit and entry unchanged
        CELL_LOAD  = 2'd1,  // take the upstream valid bit (and entry when valid)
        CELL_CLEAR = 2'd2   // drop the entry, keep stale payload bits
    } cell_op_e;

    // 32-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One register stage of the elastic chain: a valid bit plus an opaque
// entry vector. The chain decides each cycle whether the stage holds,
// loads from upstream, or is cleared by a flush.
module pipe_stage_cell
    import pipe_pkg::*;
#(
    parameter int ENTRY_W = 135
) (
    input  logic               clock,
    input  logic               reset_n,
    input  cell_op_e           op_i,
    input  logic               valid_i,
    input  logic [ENTRY_W-1:0] entry_i,
    output logic               valid_o,
    output logic [ENTRY_W-1:0] entry_o
);

    logic               valid_q;
    logic               valid_d;
    logic [ENTRY_W-1:0] entry_q;
    logic [ENTRY_W-1:0] entry_d;

    // Next-state selection: load copies the entry only for a real beat so a
    // bubble passing through leaves the previous contents in place.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        case (op_i)
            CELL_LOAD: begin
                valid_d = valid_i;
                if (valid_i) begin
                    entry_d = entry_i;
                end else begin
                    entry_d = entry_q;
                end
            end
            CELL_CLEAR: begin
                valid_d = 1'b0;
            end
            CELL_HOLD: begin
                valid_d = valid_q;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Stage register, zeroed by the asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline chain between execute and memory: DEPTH register stages
// carrying payload, rd, reg_we and data_we with valid/ready backpressure,
// bubble collapsing, synchronous flush and a combinational RAW-hazard
// lookup over every in-flight stage.
// Optional feature macro: PIPE_STALL_CNT_EN adds a saturating 32-bit
// backpressure counter on stall_count; without it stall_count reads 0.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
    parameter int RD_W      = PIPE_RD_W,
    parameter int DEPTH     = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [RD_W-1:0]      in_rd,
    input  logic                 in_reg_we,
    input  logic                 in_data_we,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [RD_W-1:0]      out_rd,
    output logic                 out_reg_we,
    output logic                 out_data_we,
    input  logic [RD_W-1:0]      query_rs1,
    input  logic [RD_W-1:0]      query_rs2,
    output logic                 hit_rs1,
    output logic                 hit_rs2,
    output logic [31:0]          stall_count
);

    // One in-flight entry as stored in a stage.
    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [RD_W-1:0]      rd;
        logic                 reg_we;
        logic                 data_we;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [DEPTH-1:0] valid_s;       // per-stage valid bits
    logic [DEPTH-1:0] move_s;        // stage contents leave this cycle
    logic [DEPTH-1:0] free_s;        // stage can take a new entry this cycle
    logic [DEPTH-1:0] load_valid_s;  // valid bit offered to each stage
    entry_t           entry_s      [DEPTH];
    entry_t           load_entry_s [DEPTH];
    cell_op_e         op_s         [DEPTH];
    logic             accept_s;
    logic             hit_rs1_s;
    logic             hit_rs2_s;

    // Advance chain, evaluated from the output side back: a stage moves when
    // the stage ahead is empty or itself moving, so holes collapse upstream.
    always_comb begin
        move_s = '0;
        move_s[DEPTH-1] = valid_s[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            move_s[i] = valid_s[i] & (~valid_s[i+1] | move_s[i+1]);
        end
        free_s = ~valid_s | move_s;
    end

    assign in_ready = ~flush & free_s[0];
    assign accept_s = in_valid & in_ready;

    // Source of each stage's load and the per-stage operation; flush wins
    // over any move or accept in the same cycle.
    always_comb begin
        load_valid_s    = '0;
        load_valid_s[0] = accept_s;
        load_entry_s[0] = '{payload: in_payload, rd: in_rd,
                            reg_we: in_reg_we, data_we: in_data_we};
        for (int i = 1; i < DEPTH; i++) begin
            load_valid_s[i] = move_s[i-1];
            load_entry_s[i] = entry_s[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                op_s[i] = CELL_CLEAR;
            end else if (free_s[i]) begin
                op_s[i] = CELL_LOAD;
            end else begin
                op_s[i] = CELL_HOLD;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [ENTRY_W-1:0] entry_vec_s;

        pipe_stage_cell #(
            .ENTRY_W (ENTRY_W)
        ) u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .op_i    (op_s[g]),
            .valid_i (load_valid_s[g]),
            .entry_i (load_entry_s[g]),
            .valid_o (valid_s[g]),
            .entry_o (entry_vec_s)
        );

        assign entry_s[g] = entry_t'(entry_vec_s);
    end

    // Hazard OR-tree over all stages; register 0 never reports a hazard and
    // the beat still on the input port is deliberately not considered.
    always_comb begin
        hit_rs1_s = 1'b0;
        hit_rs2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_s[i] && entry_s[i].reg_we) begin
                if ((entry_s[i].rd == query_rs1) && (query_rs1 != '0)) begin
                    hit_rs1_s = 1'b1;
                end else begin
                    hit_rs1_s = hit_rs1_s;
                end
                if ((entry_s[i].rd == query_rs2) && (query_rs2 != '0)) begin
                    hit_rs2_s = 1'b1;
                end else begin
                    hit_rs2_s = hit_rs2_s;
                end
            end else begin
                hit_rs1_s = hit_rs1_s;
                hit_rs2_s = hit_rs2_s;
            end
        end
    end

    assign hit_rs1 = hit_rs1_s;
    assign hit_rs2 = hit_rs2_s;

    assign out_valid   = valid_s[DEPTH-1];
    assign out_payload = entry_s[DEPTH-1].payload;
    assign out_rd      = entry_s[DEPTH-1].rd;
    assign out_reg_we  = entry_s[DEPTH-1].reg_we  & valid_s[DEPTH-1];
    assign out_data_we = entry_s[DEPTH-1].data_we & valid_s[DEPTH-1];

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;

    // Count cycles where the output holds a beat the consumer refuses.
    always_comb begin
        if (valid_s[DEPTH-1] && !out_ready) begin
            stall_d = sat_inc32(stall_q);
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register; only reset clears it, flush does not.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (DEPTH=3). The reference model
// keeps in-flight beats as a queue of (entry, stage position) records and
// moves each one forward when the position ahead of it is free.
module tb_pipe_stage_chain;

    localparam int D  = 3;
    localparam int PW = 128;
    localparam int RW = 5;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_payload;
    logic [RW-1:0] in_rd;
    logic          in_reg_we;
    logic          in_data_we;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_payload;
    logic [RW-1:0] out_rd;
    logic          out_reg_we;
    logic          out_data_we;
    logic [RW-1:0] query_rs1;
    logic [RW-1:0] query_rs2;
    logic          hit_rs1;
    logic          hit_rs2;
    logic [31:0]   stall_count;

    pipe_stage_chain #(.PAYLOAD_W(PW), .RD_W(RW), .DEPTH(D)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .in_rd       (in_rd),
        .in_reg_we   (in_reg_we),
        .in_data_we  (in_data_we),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .out_rd      (out_rd),
        .out_reg_we  (out_reg_we),
        .out_data_we (out_data_we),
        .query_rs1   (query_rs1),
        .query_rs2   (query_rs2),
        .hit_rs1     (hit_rs1),
        .hit_rs2     (hit_rs2),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [PW-1:0] p;
        logic [RW-1:0] rd;
        bit            rwe;
        bit            dwe;
        int            pos;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_cnt;
    int          n_chk = 0;
    int          n_err = 0;

    // values seen at the latest compare point, used by literal checks
    logic          obs_in_ready;
    logic          obs_out_valid;
    logic [PW-1:0] obs_payload;
    logic          obs_hit1;
    logic          obs_hit2;
    logic [31:0]   obs_stall;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Move every beat one position forward where the slot ahead frees up.
    task automatic m_advance(input bit ordy, input bit commit, output bit s0_free);
        ent_t nq[$];
        ent_t e;
        int   lim;
        lim = D - 1;
        foreach (mq[k]) begin
            e = mq[k];
            if (k == 0 && e.pos == D - 1 && ordy) continue;
            e.pos = (e.pos + 1 < lim) ? e.pos + 1 : lim;
            lim   = e.pos - 1;
            nq.push_back(e);
        end
        s0_free = (nq.size() == 0) || (nq[nq.size()-1].pos != 0);
        if (commit) mq = nq;
    endtask

    function automatic logic m_hit(input logic [RW-1:0] q);
        logic h;
        h = 1'b0;
        foreach (mq[k]) if (mq[k].rwe && mq[k].rd == q && q != '0) h = 1'b1;
        return h;
    endfunction

    // One clock cycle: drive, compare every output against the model, then
    // advance the model at the clock edge.
    task automatic step(input bit v, input logic [PW-1:0] p, input logic [RW-1:0] rd,
                        input bit rwe, input bit dwe, input bit ordy, input bit fl,
                        input logic [RW-1:0] q1, input logic [RW-1:0] q2);
        bit          s0_free;
        bit          exp_rdy;
        bit          exp_ov;
        logic [31:0] exp_cnt;
        ent_t        ne;
        @(negedge clock);
        in_valid = v; in_payload = p; in_rd = rd; in_reg_we = rwe; in_data_we = dwe;
        out_ready = ordy; flush = fl; query_rs1 = q1; query_rs2 = q2;
        #1;
        m_advance(ordy, 1'b0, s0_free);
        exp_rdy = !fl && s0_free;
        exp_ov  = (mq.size() > 0) && (mq[0].pos == D - 1);
`ifdef PIPE_STALL_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 32'd0;
`endif
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_payload", out_payload, mq[0].p);
            chk("out_rd", out_rd, mq[0].rd);
        end
        chk("out_reg_we", out_reg_we, exp_ov && mq[0].rwe);
        chk("out_data_we", out_data_we, exp_ov && mq[0].dwe);
        chk("hit_rs1", hit_rs1, m_hit(q1));
        chk("hit_rs2", hit_rs2, m_hit(q2));
        chk("stall_count", stall_count, exp_cnt);
        obs_in_ready = in_ready; obs_out_valid = out_valid; obs_payload = out_payload;
        obs_hit1 = hit_rs1; obs_hit2 = hit_rs2; obs_stall = stall_count;
        @(posedge clock);
        if (exp_ov && !ordy && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (fl) begin
            mq.delete();
        end else begin
            m_advance(ordy, 1'b1, s0_free);
            if (v && exp_rdy) begin
                ne.p = p; ne.rd = rd; ne.rwe = rwe; ne.dwe = dwe; ne.pos = 0;
                mq.push_back(ne);
            end
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, '0, '0, 1'b0, 1'b0, ordy, 1'b0, '0, '0);
    endtask

    // Reset in the middle of traffic: outputs must clear without a clock.
    task automatic reset_mid(input string tag);
        @(negedge clock);
        reset_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; query_rs1 = 5'd7; query_rs2 = 5'd3;
        #1;
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_payload"}, out_payload, '0);
        chk({tag, "_out_rd"}, out_rd, '0);
        chk({tag, "_out_we"}, {out_reg_we, out_data_we}, 2'b00);
        chk({tag, "_hits"}, {hit_rs1, hit_rs2}, 2'b00);
        chk({tag, "_stall_count"}, stall_count, 32'd0);
        mq.delete();
        m_cnt = 32'd0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        bit ordy_mode;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_payload = '0; in_rd = '0;
        in_reg_we = 1'b0; in_data_we = 1'b0; out_ready = 1'b0; query_rs1 = '0; query_rs2 = '0;
        m_cnt = 32'd0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_payload", out_payload, '0);
        chk("rst_stall_count", stall_count, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // stream 1..5 with no backpressure: first beat after DEPTH edges
        for (int k = 1; k <= 9; k++) begin
            step(k <= 5, PW'(k), RW'(k), 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
            if (k <= 5) chk("s1_in_ready", obs_in_ready, 1'b1);
            if (k >= 4 && k <= 8) begin
                chk("s1_out_valid", obs_out_valid, 1'b1);
                chk("s1_payload", obs_payload, PW'(k - 3));
            end else begin
                chk("s1_out_idle", obs_out_valid, 1'b0);
            end
        end

        // backpressure: three beats fill the chain, the fourth waits
        for (int k = 0; k < 4; k++) begin
            step(1'b1, PW'(32'hA + k), '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            chk("s2_in_ready", obs_in_ready, k < 3);
        end
        chk("s2_head_held", obs_payload, PW'(32'hA));
        step(1'b1, PW'(32'hD), '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("s2_release_ready", obs_in_ready, 1'b1);
        chk("s2_release_head", obs_payload, PW'(32'hA));
        for (int k = 1; k <= 3; k++) begin
            idle(1'b1);
            chk("s2_drain", obs_payload, PW'(32'hA + k));
        end
        idle(1'b1);
        chk("s2_empty", obs_out_valid, 1'b0);

        // bubble collapse under a stalled output
        step(1'b1, PW'(32'hA), '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        idle(1'b0);
        step(1'b1, PW'(32'hB), '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        idle(1'b0);
        idle(1'b0);
        chk("s3_collapsed_ready", obs_in_ready, 1'b1);
        chk("s3_head", obs_payload, PW'(32'hA));
        idle(1'b1);
        chk("s3_out_a", obs_payload, PW'(32'hA));
        idle(1'b1);
        chk("s3_out_b", obs_payload, PW'(32'hB));
        idle(1'b1);

        // hazard lookup corner cases
        step(1'b1, PW'(1), 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0);
        chk("hz_input_excluded", obs_hit1, 1'b0);
        step(1'b1, PW'(2), 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0);
        chk("hz_rd7_hit", obs_hit1, 1'b1);
        step(1'b1, PW'(3), 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd9);
        chk("hz_rd0_excluded", obs_hit1, 1'b0);
        idle(1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd9);
        chk("hz_out_stage_hit", obs_hit1, 1'b1);
        chk("hz_no_reg_we", obs_hit2, 1'b0);

        // flush with a beat offered: nothing consumed, chain empty after
        step(1'b1, PW'(32'h55), 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd4);
        chk("fl_in_ready", obs_in_ready, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd4);
        chk("fl_out_valid", obs_out_valid, 1'b0);
        chk("fl_hits", {obs_hit1, obs_hit2}, 2'b00);

        // ten stalled cycles with a valid head
        reset_mid("r1");
        step(1'b1, PW'(32'h77), '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        idle(1'b0);
        idle(1'b0);
        for (int k = 0; k < 10; k++) idle(1'b0);
        idle(1'b0);
`ifdef PIPE_STALL_CNT_EN
        chk("stall_10", obs_stall, 32'd10);
`else
        chk("stall_tied", obs_stall, 32'd0);
`endif
        reset_mid("r2");

        // randomized traffic with occasional flush and one mid-run reset
        ordy_mode = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) ordy_mode = ~ordy_mode;
            if (n == 300) reset_mid("r3");
            step($urandom_range(0, 3) != 0,
                 {$urandom, $urandom, $urandom, $urandom},
                 RW'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 ordy_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 19) == 0,
                 RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
